mem_responder: RTL and testbench

Memory-side responder for the datapath's memory bus. It samples the MAR address and MDR write data when the control unit raises `read` or `write`, waits a fixed number of cycles, and then performs the access on an internal word-addressed RAM. It returns read data on `rd_data`, which feeds the datapath `MDatain`, and pulses `done` so the control unit can leave its memory T-step. It sits beside the datapath and pairs with the control unit's `Read`/`Write` strobes.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array.sv | 36 +++
 rtl/mem_responder.sv | 116 +++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its RAM.
package mem_pkg;
   localparam int ADDR_W_DEF      = 9;
   localparam int DATA_W_DEF      = 32;
   localparam int WAIT_CYCLES_DEF = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; the read register only loads on re_i so it
// holds the last read word between accesses.
module mem_array #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         ram[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= ram[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: edge-triggered request accept, fixed wait states, one access.
// Define MEM_ADDR_CHECK_EN to reject requests with nonzero upper address bits.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       mar_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              busy,
   output logic              err
);
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              req_q;
   logic              done_q;
   logic              busy_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              op_wr_q;

   logic req;
   logic req_edge;
   logic addr_bad;
   logic reject;
   logic access;

   assign req      = read | write;
   assign req_edge = req & ~req_q;

`ifdef MEM_ADDR_CHECK_EN
   assign addr_bad = |mar_addr[31:ADDR_W];
`else
   logic addr_hi_unused;
   assign addr_bad       = 1'b0;
   assign addr_hi_unused = |mar_addr[31:ADDR_W];
`endif

   assign reject = (read & write) | addr_bad;

   // Gated by reset so a pending write is dropped if reset lands on the access edge.
   assign access = (state_q == WAIT) && (cnt_q == '0) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         op_wr_q <= 1'b0;
      end else begin
         req_q  <= req;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_edge) begin
                  if (reject) begin
                     err_q <= 1'b1;
                  end else begin
                     addr_q  <= mar_addr[ADDR_W-1:0];
                     data_q  <= wr_data;
                     op_wr_q <= write;
                     cnt_q   <= CNT_W'(WAIT_CYCLES);
                     busy_q  <= 1'b1;
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   mem_array #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_array (
      .clk     (clk),
      .reset_i (reset),
      .we_i    (access & op_wr_q),
      .re_i    (access & ~op_wr_q),
      .addr_i  (addr_q),
      .wdata_i (data_q),
      .rdata_o (rd_data)
   );

   assign done = done_q;
   assign busy = busy_q;
   assign err  = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table with scoreboard, plus reset and zero-wait sequences.
module tb_mem_responder;
   localparam int W = 2;
`ifdef MEM_ADDR_CHECK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mar_addr, wr_data, rd_data;
   logic        read, write, done, busy, err;
   logic [31:0] mar0, wd0, rdd0;
   logic        rd0, wr0, done0, busy0, err0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .mar_addr(mar_addr), .wr_data(wr_data),
      .read(read), .write(write), .rd_data(rd_data), .done(done),
      .busy(busy), .err(err)
   );

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .reset(reset), .mar_addr(mar0), .wr_data(wd0),
      .read(rd0), .write(wr0), .rd_data(rdd0), .done(done0),
      .busy(busy0), .err(err0)
   );

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          hold;
      bit          exp_err;
      logic [31:0] exp_rd;
      string       tag;
   } vec_t;
   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs the cycles after an acceptance edge, popping the scoreboard on done.
   task automatic wait_resp(input bit accepted, input int hold, input string tag);
      int   ndone;
      int   lim;
      exp_t e;
      ndone = 0;
      lim = ((hold > W + 3) ? hold : W + 3) + 1;
      for (int k = 1; k <= lim; k++) begin
         if (k >= hold) begin
            read  = 1'b0;
            write = 1'b0;
         end
         tick();
         if (done) begin
            ndone++;
            if (accepted) chk({tag, " done_lat"}, k, W + 1);
            if (sb.size() == 0) begin
               n_chk++;
               n_bad++;
               $display("FAIL %s sb_empty: done with no pending access", tag);
            end else begin
               e = sb.pop_front();
               if (e.is_read) chk({tag, " rd_data"}, rd_data, e.data);
            end
         end
         chk({tag, " busy"}, 32'(busy), 32'(accepted && (k <= W + 1)));
         chk({tag, " err_low"}, 32'(err), 32'd0);
      end
      chk({tag, " n_done"}, ndone, accepted ? 1 : 0);
      $display("txn %s: accepted=%0d done_count=%0d rd_data=%h", tag, accepted, ndone, rd_data);
   endtask

   task automatic access(input vec_t v);
      exp_t e;
      read     = v.rd;
      write    = v.wr;
      mar_addr = v.addr;
      wr_data  = v.data;
      if (!v.exp_err) begin
         e.is_read = v.rd;
         e.data    = v.exp_rd;
         sb.push_back(e);
      end
      tick();
      chk({v.tag, " busy_acc"}, 32'(busy), 32'(!v.exp_err));
      chk({v.tag, " err_acc"}, 32'(err), 32'(v.exp_err));
      chk({v.tag, " done_acc"}, 32'(done), 32'd0);
      wait_resp(!v.exp_err, v.hold, v.tag);
   endtask

   initial begin
      vt[0]  = '{1'b0, 1'b1, 32'h085, 32'h12345678, 1, 1'b0, 32'h0, "wr085"};
      vt[1]  = '{1'b1, 1'b0, 32'h085, 32'h0, 1, 1'b0, 32'h12345678, "rd085"};
      vt[2]  = '{1'b0, 1'b1, 32'h010, 32'hA5A50010, 1, 1'b0, 32'h0, "wr010"};
      vt[3]  = '{1'b0, 1'b1, 32'h1FF, 32'hFFFF0000, 1, 1'b0, 32'h0, "wr1ff"};
      vt[4]  = '{1'b0, 1'b1, 32'h000, 32'h00000001, 3, 1'b0, 32'h0, "wr000"};
      vt[5]  = '{1'b1, 1'b0, 32'h1FF, 32'h0, 1, 1'b0, 32'hFFFF0000, "rd1ff"};
      vt[6]  = '{1'b1, 1'b0, 32'h000, 32'h0, 1, 1'b0, 32'h00000001, "rd000"};
      vt[7]  = '{1'b1, 1'b1, 32'h010, 32'h0BAD0BAD, 1, 1'b1, 32'h0, "both010"};
      vt[8]  = '{1'b1, 1'b0, 32'h010, 32'h0, 1, 1'b0, 32'hA5A50010, "rd010"};
      vt[9]  = '{1'b1, 1'b0, 32'h085, 32'h0, 8, 1'b0, 32'h12345678, "held085"};
      vt[10] = '{1'b0, 1'b1, 32'h005, 32'h00000055, 1, 1'b0, 32'h0, "wr005"};
      vt[11] = '{1'b0, 1'b1, 32'h205, 32'h00000077, 1, ADDR_CHK, 32'h0, "wr205"};
      vt[12] = '{1'b1, 1'b0, 32'h005, 32'h0, 1, 1'b0,
                 ADDR_CHK ? 32'h00000055 : 32'h00000077, "rd005"};
      vt[13] = '{1'b0, 1'b1, 32'h020, 32'h0BADF00D, 1, 1'b0, 32'h0, "wr020"};
      vt[14] = '{1'b1, 1'b0, 32'hA85, 32'h0, 1, ADDR_CHK, 32'h12345678, "rdA85"};

      reset = 1'b1; read = 1'b0; write = 1'b0; mar_addr = '0; wr_data = '0;
      rd0 = 1'b0; wr0 = 1'b0; mar0 = '0; wd0 = '0;
      repeat (3) tick();
      chk("rst rd_data", rd_data, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 15; i++) access(vt[i]);

      // Reset one cycle after accepting a write: the write must vanish.
      write = 1'b1; mar_addr = 32'h020; wr_data = 32'hDEADBEEF;
      tick();
      chk("rstw busy_acc", 32'(busy), 32'd1);
      write = 1'b0;
      reset = 1'b1;
      tick();
      chk("rstw busy", 32'(busy), 32'd0);
      chk("rstw done", 32'(done), 32'd0);
      chk("rstw rd_data", rd_data, 32'd0);
      $display("txn rst_wait: busy=%0d done=%0d", busy, done);

      // Read strobe held through reset release is accepted on the first free edge.
      read = 1'b1; mar_addr = 32'h020;
      tick();
      reset = 1'b0;
      tick();
      chk("rsthold busy_acc", 32'(busy), 32'd1);
      chk("rsthold done_acc", 32'(done), 32'd0);
      sb.push_back('{1'b1, 32'h0BADF00D});
      wait_resp(1'b1, 3, "rsthold_rd020");

      // Zero wait states: write then read on the second instance.
      wr0 = 1'b1; mar0 = 32'h033; wd0 = 32'hCAFE0033;
      tick();
      chk("w0 wr busy_acc", 32'(busy0), 32'd1);
      chk("w0 wr done_acc", 32'(done0), 32'd0);
      wr0 = 1'b0;
      tick();
      chk("w0 wr done", 32'(done0), 32'd1);
      chk("w0 wr busy1", 32'(busy0), 32'd1);
      tick();
      chk("w0 wr busy_end", 32'(busy0), 32'd0);
      $display("txn w0_wr033: busy=%0d done=%0d", busy0, done0);
      rd0 = 1'b1; mar0 = 32'h033;
      tick();
      chk("w0 rd busy_acc", 32'(busy0), 32'd1);
      rd0 = 1'b0;
      tick();
      chk("w0 rd done", 32'(done0), 32'd1);
      chk("w0 rd rd_data", rdd0, 32'hCAFE0033);
      chk("w0 rd busy1", 32'(busy0), 32'd1);
      tick();
      chk("w0 rd busy_end", 32'(busy0), 32'd0);
      chk("w0 rd done_end", 32'(done0), 32'd0);
      chk("w0 err", 32'(err0), 32'd0);
      $display("txn w0_rd033: rd_data=%h", rdd0);

      chk("sb drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
